dq_turnaround_tracker: RTL

- Channel-level DQ bus turnaround tracker for multi-rank channels; successor to the single-counter turnaround grant.
- Tracks every issued CAS and enforces the following per target rank:
  - read->write (tRTW)
  - write->read same rank (tWTRS)
  - write->read different rank (tWTRL)
  - read->read rank switch (tRTRS)
- Sits beside the channel controller, which qualifies RD/WR CAS issue with rdGrant/wrGrant.
- Flags any CAS issued against a closed grant.

---
 rtl/dq_ta_pkg.sv | 34 +++
 rtl/ta_window_counter.sv | 43 ++++
 rtl/dq_turnaround_tracker.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dq_ta_pkg.sv
// ----------------------------------------------------------------------------
// dq_ta_pkg: shared helpers and CAS type for the DQ turnaround tracker.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dq_ta_pkg;

    typedef enum logic {
        CAS_RD = 1'b0,
        CAS_WR = 1'b1
    } cas_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int max_timing(input int a, input int b,
                                      input int c, input int d);
        return max2(max2(a, b), max2(c, d));
    endfunction

    // Counter width able to hold values 0..max_t
    function automatic int cnt_width(input int max_t);
        return max2(1, $clog2(max_t + 1));
    endfunction

    function automatic int rank_width(input int num_ranks);
        return max2(1, $clog2(num_ranks));
    endfunction

endpackage

`default_nettype wire

// File: rtl/ta_window_counter.sv
// ----------------------------------------------------------------------------
// ta_window_counter: saturating down counter; a load never shortens the window.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ta_window_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] loadVal_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] dec;

    always_comb begin
        dec   = (cnt_q == '0) ? '0 : cnt_q - W'(1);
        cnt_d = dec;
        if (load_i && (loadVal_i > dec)) begin
            cnt_d = loadVal_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/dq_turnaround_tracker.sv
// ----------------------------------------------------------------------------
// dq_turnaround_tracker: multi-rank DQ bus turnaround tracker producing per-rank
// read grants, a write grant, and a one-cycle violation flag.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dq_turnaround_tracker
    import dq_ta_pkg::*;
#(
    parameter int NUM_RANKS = 2,
    parameter int tRTW      = 8,
    parameter int tWTRS     = 3,
    parameter int tWTRL     = 9,
    parameter int tRTRS     = 2,
    localparam int RANK_W   = rank_width(NUM_RANKS),
    localparam int MAX_T    = max_timing(tRTW, tWTRS, tWTRL, tRTRS),
    localparam int CNT_W    = cnt_width(MAX_T)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 casValid_i,
    input  logic                 casIsWrite_i,
    input  logic [RANK_W-1:0]    casRank_i,
    output logic [NUM_RANKS-1:0] rdGrant_o,
    output logic                 wrGrant_o,
    output logic                 busMode_o,
    output logic [RANK_W-1:0]    lastRank_o,
    output logic                 allFree_o,
    output logic                 violation_o
);

    localparam logic [CNT_W-1:0] LD_RTW  = CNT_W'(tRTW - 1);
    localparam logic [CNT_W-1:0] LD_WTRS = CNT_W'(tWTRS - 1);
    localparam logic [CNT_W-1:0] LD_WTRL = CNT_W'(tWTRL - 1);
    localparam logic [CNT_W-1:0] LD_RTRS = CNT_W'(tRTRS - 1);

    logic                 busMode_q;
    logic [RANK_W-1:0]    lastRank_q;
    logic [RANK_W-1:0]    lastRdRank_q;
    logic                 violation_q;
    logic                 violation_d;

    logic                 rankOk;
    logic                 rdLoad;
    logic                 wrLoad;
    logic                 granted;

    logic [CNT_W-1:0]     wrCnt;
    logic [CNT_W-1:0]     swCnt;
    logic                 wrZero;
    logic                 swZero;
    logic [NUM_RANKS-1:0] rdZero;
    logic [CNT_W-1:0]     rdCnt [NUM_RANKS];
    logic [NUM_RANKS-1:0] rdCntNz;

    assign rankOk = ({{(32 - RANK_W){1'b0}}, casRank_i} < 32'(NUM_RANKS));

    // Out-of-range ranks are flagged but never allowed to open a window
    assign rdLoad = casValid_i && rankOk && (cas_e'(casIsWrite_i) == CAS_RD);
    assign wrLoad = casValid_i && rankOk && (cas_e'(casIsWrite_i) == CAS_WR);

    ta_window_counter #(.W(CNT_W)) u_wr_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (rdLoad),
        .loadVal_i (LD_RTW),
        .cnt_o     (wrCnt),
        .zero_o    (wrZero)
    );

    ta_window_counter #(.W(CNT_W)) u_sw_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (rdLoad),
        .loadVal_i (LD_RTRS),
        .cnt_o     (swCnt),
        .zero_o    (swZero)
    );

    generate
        for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
            logic [CNT_W-1:0] ldVal;

            assign ldVal = (casRank_i == RANK_W'(r)) ? LD_WTRS : LD_WTRL;

            ta_window_counter #(.W(CNT_W)) u_rd_cnt (
                .clk       (clk),
                .rst       (rst),
                .load_i    (wrLoad),
                .loadVal_i (ldVal),
                .cnt_o     (rdCnt[r]),
                .zero_o    (rdZero[r])
            );

            assign rdCntNz[r]   = |rdCnt[r];
            assign rdGrant_o[r] = rdZero[r] &&
                                  ((lastRdRank_q == RANK_W'(r)) || swZero);
        end
    endgenerate

    assign wrGrant_o = wrZero;
    assign allFree_o = ~(|wrCnt) && ~(|swCnt) && ~(|rdCntNz);

    always_comb begin
        granted = 1'b0;
        if (rankOk) begin
            granted = casIsWrite_i ? wrGrant_o : rdGrant_o[casRank_i];
        end
        violation_d = casValid_i && !granted;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busMode_q    <= 1'b0;
            lastRank_q   <= '0;
            lastRdRank_q <= '0;
            violation_q  <= 1'b0;
        end else begin
            violation_q <= violation_d;
            if (casValid_i) begin
                busMode_q  <= casIsWrite_i;
                lastRank_q <= casRank_i;
            end
            if (rdLoad) begin
                lastRdRank_q <= casRank_i;
            end
        end
    end

    assign busMode_o   = busMode_q;
    assign lastRank_o  = lastRank_q;
    assign violation_o = violation_q;

`ifdef DISPLAY
    always_ff @(posedge clk) begin
        if (!rst && casValid_i && rankOk) begin
            $display("%t dq_ta: %s CAS rank %0d opens window", $time,
                     casIsWrite_i ? "WR" : "RD", casRank_i);
        end
        if (!rst && violation_d) begin
            $display("%t dq_ta: CAS without grant (wr=%0b rank=%0d)", $time,
                     casIsWrite_i, casRank_i);
        end
    end
`endif

endmodule

`default_nettype wire
